// File: rtl/cv_xalu_decode_stage.sv
// Pre-decode stage for the custom ALU / immediate-branch extension.
// Classifies raw instruction words, extracts fields and immediates, and
// delivers them through a registered main slot backed by a one-entry skid slot.
module cv_xalu_decode_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [1:0]       dec_class_o,
  output logic             dec_illegal_o,
  output logic [9:0]       dec_funct_o,
  output logic [4:0]       dec_rd_o,
  output logic [4:0]       dec_rs1_o,
  output logic [4:0]       dec_rs2_o,
  output logic [31:0]      dec_imm_o,
  output logic [31:0]      dec_imm5_o,
  output logic [31:0]      dec_pc_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_custom_o,
  output logic [CNT_W-1:0] cnt_illegal_o
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FUNCT_W = 10;
  localparam int unsigned REG_W   = 5;

  localparam logic [6:0] OPC_REG    = 7'h2B;
  localparam logic [6:0] OPC_IMM    = 7'h5B;
  localparam logic [6:0] OPC_BRANCH = 7'h0B;

  localparam logic [1:0] CLS_OTHER  = 2'd0;
  localparam logic [1:0] CLS_REG    = 2'd1;
  localparam logic [1:0] CLS_IMM    = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

  typedef struct packed {
    logic [1:0]         cls;
    logic               illegal;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    imm5;
    logic [XLEN-1:0]    pc;
  } dec_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] f2;
  logic       reg_f7_ok;
  logic       imm_ok;
  dec_t       dec_c;

  dec_t             main_q, main_d;
  dec_t             skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_custom_q, cnt_custom_d;
  logic [CNT_W-1:0] cnt_illegal_q, cnt_illegal_d;

  logic accept;
  logic consume;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign f2     = instr_i[31:30];

  // Supported funct7 encodings of the register-register custom ALU ops
  always_comb begin
    reg_f7_ok = 1'b0;
    case (funct7) inside
      7'h18, 7'h19, 7'h1A, 7'h1C, 7'h1D,
      [7'h20:7'h24], [7'h28:7'h2E], [7'h30:7'h33],
      [7'h38:7'h3B], [7'h40:7'h47]: reg_f7_ok = 1'b1;
      default:                      reg_f7_ok = 1'b0;
    endcase
  end

  // Supported {funct3, f2} combinations of the immediate custom ALU ops
  always_comb begin
    imm_ok = 1'b0;
    case (funct3)
      3'b000:         imm_ok = (f2 != 2'b11);
      3'b001:         imm_ok = (f2 != 2'b10);
      3'b010, 3'b011: imm_ok = 1'b1;
      default:        imm_ok = 1'b0;
    endcase
  end

  // Combinational decode of the presented word
  always_comb begin
    dec_c     = '0;
    dec_c.rd  = instr_i[11:7];
    dec_c.rs1 = instr_i[19:15];
    dec_c.rs2 = instr_i[24:20];
    dec_c.pc  = pc_i;
    case (opcode)
      OPC_REG: begin
        dec_c.cls     = CLS_REG;
        dec_c.funct   = {funct7, funct3};
        dec_c.illegal = !((funct3 == 3'b011) && reg_f7_ok);
      end
      OPC_IMM: begin
        dec_c.cls     = CLS_IMM;
        dec_c.funct   = {5'b0, f2, funct3};
        dec_c.illegal = !imm_ok;
        dec_c.imm     = {27'b0, instr_i[29:25]};
        dec_c.imm5    = {27'b0, instr_i[24:20]};
      end
      OPC_BRANCH: begin
        dec_c.cls     = CLS_BRANCH;
        dec_c.funct   = {7'b0, funct3};
        dec_c.illegal = (funct3[2:1] != 2'b11);
        dec_c.imm     = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
        dec_c.imm5    = {{27{instr_i[24]}}, instr_i[24:20]};
      end
      default: dec_c.cls = CLS_OTHER;
    endcase
    if (dec_c.illegal) begin
      dec_c.imm  = '0;
      dec_c.imm5 = '0;
    end
  end

  assign accept  = instr_valid_i & rdy_q;
  assign consume = main_v_q & dec_ready_i;

  // Next state of the main/skid slots and the statistics counters
  always_comb begin
    main_d        = main_q;
    skid_d        = skid_q;
    main_v_d      = main_v_q;
    skid_v_d      = skid_v_q;
    cnt_custom_d  = cnt_custom_q;
    cnt_illegal_d = cnt_illegal_q;

    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (consume) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = dec_c;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      if (main_v_q) begin
        skid_d   = dec_c;
        skid_v_d = 1'b1;
      end else begin
        main_d   = dec_c;
        main_v_d = 1'b1;
      end
    end

    rdy_d = !skid_v_d;

    if (cnt_clr_i) begin
      cnt_custom_d  = '0;
      cnt_illegal_d = '0;
    end else if (consume) begin
      if (main_q.illegal) begin
        if (cnt_illegal_q != '1) cnt_illegal_d = cnt_illegal_q + CNT_W'(1);
      end else if (main_q.cls != CLS_OTHER) begin
        if (cnt_custom_q != '1) cnt_custom_d = cnt_custom_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_v_q      <= 1'b0;
      skid_v_q      <= 1'b0;
      rdy_q         <= 1'b1;
      cnt_custom_q  <= '0;
      cnt_illegal_q <= '0;
    end else begin
      main_q        <= main_d;
      skid_q        <= skid_d;
      main_v_q      <= main_v_d;
      skid_v_q      <= skid_v_d;
      rdy_q         <= rdy_d;
      cnt_custom_q  <= cnt_custom_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  assign instr_ready_o = rdy_q;
  assign dec_valid_o   = main_v_q;
  assign dec_class_o   = main_q.cls;
  assign dec_illegal_o = main_q.illegal;
  assign dec_funct_o   = main_q.funct;
  assign dec_rd_o      = main_q.rd;
  assign dec_rs1_o     = main_q.rs1;
  assign dec_rs2_o     = main_q.rs2;
  assign dec_imm_o     = main_q.imm;
  assign dec_imm5_o    = main_q.imm5;
  assign dec_pc_o      = main_q.pc;
  assign cnt_custom_o  = cnt_custom_q;
  assign cnt_illegal_o = cnt_illegal_q;

endmodule

// File: tb/tb_cv_xalu_decode_stage.sv
// Directed bench for cv_xalu_decode_stage with hand-computed expectations.
module tb_cv_xalu_decode_stage;

  localparam int unsigned CNT_W = 2;
  localparam logic [31:0] SAT   = 32'(2 ** CNT_W - 1);

  logic             clk_i;
  logic             rst_ni;
  logic             flush_i;
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instr_i;
  logic [31:0]      pc_i;
  logic             dec_valid_o;
  logic             dec_ready_i;
  logic [1:0]       dec_class_o;
  logic             dec_illegal_o;
  logic [9:0]       dec_funct_o;
  logic [4:0]       dec_rd_o;
  logic [4:0]       dec_rs1_o;
  logic [4:0]       dec_rs2_o;
  logic [31:0]      dec_imm_o;
  logic [31:0]      dec_imm5_o;
  logic [31:0]      dec_pc_o;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] cnt_custom_o;
  logic [CNT_W-1:0] cnt_illegal_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_c = '0;
  logic [31:0] exp_i = '0;

  cv_xalu_decode_stage #(.CNT_W(CNT_W)) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_class_o   (dec_class_o),
    .dec_illegal_o (dec_illegal_o),
    .dec_funct_o   (dec_funct_o),
    .dec_rd_o      (dec_rd_o),
    .dec_rs1_o     (dec_rs1_o),
    .dec_rs2_o     (dec_rs2_o),
    .dec_imm_o     (dec_imm_o),
    .dec_imm5_o    (dec_imm5_o),
    .dec_pc_o      (dec_pc_o),
    .cnt_clr_i     (cnt_clr_i),
    .cnt_custom_o  (cnt_custom_o),
    .cnt_illegal_o (cnt_illegal_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == SAT) ? v : v + 32'd1;
  endfunction

  task automatic check_cnts(input string tag);
    check_eq({tag, "_cnt_custom"}, 32'(cnt_custom_o), exp_c);
    check_eq({tag, "_cnt_illegal"}, 32'(cnt_illegal_o), exp_i);
  endtask

  // Present one word, check the decoded entry, then consume it.
  task automatic xfer(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [1:0] cls, input logic ill, input logic [9:0] fn,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] imm5);
    int n;
    n = 0;
    instr_i       = ins;
    pc_i          = pc;
    instr_valid_i = 1'b1;
    dec_ready_i   = 1'b0;
    while (!instr_ready_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n == 10) check_eq({tag, "_accept_timeout"}, 32'(instr_ready_o), 32'd1);
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    check_eq({tag, "_valid"},   32'(dec_valid_o), 32'd1);
    check_eq({tag, "_class"},   32'(dec_class_o), 32'(cls));
    check_eq({tag, "_illegal"}, 32'(dec_illegal_o), 32'(ill));
    check_eq({tag, "_funct"},   32'(dec_funct_o), 32'(fn));
    check_eq({tag, "_rd"},      32'(dec_rd_o), 32'(rd));
    check_eq({tag, "_rs1"},     32'(dec_rs1_o), 32'(rs1));
    check_eq({tag, "_rs2"},     32'(dec_rs2_o), 32'(rs2));
    check_eq({tag, "_imm"},     dec_imm_o, imm);
    check_eq({tag, "_imm5"},    dec_imm5_o, imm5);
    check_eq({tag, "_pc"},      dec_pc_o, pc);
    dec_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dec_ready_i = 1'b0;
    if (ill)                    exp_i = sat_inc(exp_i);
    else if (cls != 2'd0)       exp_c = sat_inc(exp_c);
    check_eq({tag, "_drained"}, 32'(dec_valid_o), 32'd0);
    check_cnts(tag);
  endtask

  initial begin
    int          k;
    int          nrx;
    logic        rdy;
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    pc_i          = '0;
    dec_ready_i   = 1'b0;
    cnt_clr_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    check_eq("rst_valid", 32'(dec_valid_o), 32'd0);
    check_eq("rst_ready", 32'(instr_ready_o), 32'd1);
    check_eq("rst_class", 32'(dec_class_o), 32'd0);
    check_eq("rst_imm",   dec_imm_o, 32'd0);
    check_eq("rst_pc",    dec_pc_o, 32'd0);
    check_cnts("rst");

    xfer("reg",      32'h403130AB, 32'h100, 2'd1, 1'b0, 10'h103, 5'd1,  5'd2, 5'd3,  32'h0,        32'h0);
    xfer("reg_ill",  32'h3600302B, 32'h104, 2'd1, 1'b1, 10'h0DB, 5'd0,  5'd0, 5'd0,  32'h0,        32'h0);
    xfer("imm",      32'h0E32015B, 32'h108, 2'd2, 1'b0, 10'h000, 5'd2,  5'd4, 5'd3,  32'h7,        32'h3);
    xfer("br",       32'h01F2E00B, 32'h10C, 2'd3, 1'b0, 10'h006, 5'd0,  5'd5, 5'd31, 32'h0,        32'hFFFFFFFF);
    xfer("br_ill",   32'h01F2C00B, 32'h110, 2'd3, 1'b1, 10'h004, 5'd0,  5'd5, 5'd31, 32'h0,        32'h0);
    xfer("br_off",   32'h8230F58B, 32'h114, 2'd3, 1'b0, 10'h007, 5'd11, 5'd1, 5'd3,  32'hFFFFF82A, 32'h3);
    xfer("other",    32'h00208033, 32'h118, 2'd0, 1'b0, 10'h000, 5'd0,  5'd1, 5'd2,  32'h0,        32'h0);
    xfer("imm_ill",  32'hCE32015B, 32'h11C, 2'd2, 1'b1, 10'h018, 5'd2,  5'd4, 5'd3,  32'h0,        32'h0);
    xfer("imm_f001", 32'hCE32115B, 32'h120, 2'd2, 1'b0, 10'h019, 5'd2,  5'd4, 5'd3,  32'h7,        32'h3);

    // Backpressure: four words offered while the consumer stalls
    k = 0;
    instr_i = 32'h403130AB;
    for (int c = 0; c < 4; c++) begin
      instr_valid_i = (k < 4);
      pc_i          = 32'h200 + 32'(4 * k);
      rdy           = instr_ready_o;
      @(posedge clk_i); #1;
      if (rdy && instr_valid_i) k++;
    end
    check_eq("bp_accepted", 32'(k), 32'd2);
    check_eq("bp_ready",    32'(instr_ready_o), 32'd0);
    check_eq("bp_valid",    32'(dec_valid_o), 32'd1);
    check_eq("bp_hold_pc",  dec_pc_o, 32'h200);

    // Release: words must emerge in order, one per cycle
    nrx         = 0;
    dec_ready_i = 1'b1;
    for (int c = 0; c < 12 && nrx < 4; c++) begin
      instr_valid_i = (k < 4);
      pc_i          = 32'h200 + 32'(4 * k);
      rdy           = instr_ready_o;
      if (dec_valid_o) begin
        check_eq("bp_order", dec_pc_o, 32'h200 + 32'(4 * nrx));
        nrx++;
        exp_c = sat_inc(exp_c);
      end
      @(posedge clk_i); #1;
      if (rdy && instr_valid_i) k++;
    end
    instr_valid_i = 1'b0;
    dec_ready_i   = 1'b0;
    check_eq("bp_received", 32'(nrx), 32'd4);
    check_eq("bp_empty",    32'(dec_valid_o), 32'd0);
    check_cnts("bp");

    // Fill both slots, then flush with a word presented
    k = 0;
    for (int c = 0; c < 3; c++) begin
      instr_valid_i = (k < 2);
      pc_i          = 32'h300 + 32'(4 * k);
      rdy           = instr_ready_o;
      @(posedge clk_i); #1;
      if (rdy && instr_valid_i) k++;
    end
    check_eq("fl_full_ready", 32'(instr_ready_o), 32'd0);
    check_eq("fl_full_valid", 32'(dec_valid_o), 32'd1);
    flush_i       = 1'b1;
    instr_valid_i = 1'b1;
    pc_i          = 32'h3F0;
    @(posedge clk_i); #1;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    check_eq("fl_valid", 32'(dec_valid_o), 32'd0);
    check_eq("fl_ready", 32'(instr_ready_o), 32'd1);
    check_cnts("fl");
    @(posedge clk_i); #1;
    check_eq("fl_still_empty", 32'(dec_valid_o), 32'd0);
    check_eq("fl_hold_pc",     dec_pc_o, 32'h300);

    // Clear has priority over a simultaneous handshake
    instr_i       = 32'h403130AB;
    pc_i          = 32'h400;
    instr_valid_i = 1'b1;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    check_eq("clr_valid", 32'(dec_valid_o), 32'd1);
    dec_ready_i = 1'b1;
    cnt_clr_i   = 1'b1;
    @(posedge clk_i); #1;
    dec_ready_i = 1'b0;
    cnt_clr_i   = 1'b0;
    exp_c = 32'd0;
    exp_i = 32'd0;
    check_cnts("clr");
    xfer("post_clr", 32'h403130AB, 32'h404, 2'd1, 1'b0, 10'h103, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
